// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell reused LSB first,
// one bit per clock, with a start/done handshake and a held result register.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             cell_d, cell_bo;

  // Returns {borrow_out, difference} of a single-bit full subtractor.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bi);
    logic d, bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~x & bi) | (y & bi);
    return {bo, d};
  endfunction

  always_comb begin
    {cell_bo, cell_d} = sub_cell(a_sh_q[0], b_sh_q[0], br_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    br_d      = br_q;
    diff_d    = diff_q;
    bo_d      = bo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d    = a;
          b_sh_d    = b;
          br_d      = bin;
          diff_sh_d = '0;
          cnt_d     = '0;
          state_d   = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        br_d      = cell_bo;
        if (cnt_q == LAST_BIT) begin
          // Publish only the complete result so diff never shows partial bits.
          diff_d  = {cell_d, diff_sh_q[WIDTH-1:1]};
          bo_d    = cell_bo;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      br_q      <= 1'b0;
      diff_q    <= '0;
      bo_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      br_q      <= br_d;
      diff_q    <= diff_d;
      bo_q      <= bo_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: directed cases with literal results plus random
// traffic, all checked every cycle against a latency/arithmetic model.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done, borrow_out;
  logic [WIDTH-1:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operation keeps busy high for WIDTH cycles, then one
  // done cycle publishes (a - b - bin) computed with plain arithmetic.
  int               m_left = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_bo   = 1'b0;
  logic [WIDTH-1:0] p_diff = '0;
  logic             p_bo   = 1'b0;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    logic         acc, nd;
    logic [WIDTH:0] t;
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_diff = '0; m_bo = 1'b0;
    end else begin
      acc = start && (m_left == 0);
      nd  = (m_left == 1);
      if (m_left > 0) m_left--;
      if (nd) begin
        m_diff = p_diff;
        m_bo   = p_bo;
      end
      if (acc) begin
        t      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        p_diff = t[WIDTH-1:0];
        p_bo   = t[WIDTH];
        m_left = WIDTH;
      end
      m_done = nd;
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_bo));
      chk("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  // Called and returns on a negedge; checks latency, busy length and result literals.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tbin, input logic [WIDTH-1:0] ed, input logic eb);
    int k, busy_cnt;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    busy_cnt = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) break;
      @(posedge clk);
    end
    if (k == 40) chk("op_timeout", 32'd1, 32'd0);
    else begin
      chk("op_latency", 32'(k), 32'(WIDTH));
      chk("op_busy_len", 32'(busy_cnt), 32'(WIDTH));
      chk("op_diff", 32'(diff), 32'(ed));
      chk("op_borrow", 32'(borrow_out), 32'(eb));
    end
  endtask

  initial begin
    int dcnt, k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bo", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    @(negedge clk);
    run_op(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1);
    run_op(8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    @(negedge clk);

    // start during RUN must be ignored
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        chk("ignore_diff", 32'(diff), 32'h1E);
      end
    end
    chk("ignore_done_cnt", 32'(dcnt), 32'd1);

    // back-to-back launch across DONE
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h80; b = 8'h01;
    for (k = 0; k < 40 && !done; k++) @(negedge clk);
    chk("b2b_first_seen", 32'(done), 32'd1);
    chk("b2b_first_diff", 32'(diff), 32'h1E);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (k = 1; k < 40 && !done; k++) @(negedge clk);
    chk("b2b_gap", 32'(k), 32'(WIDTH + 1));
    chk("b2b_diff", 32'(diff), 32'h7F);
    chk("b2b_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);

    // reset in the middle of RUN
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bo", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run_op(8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1);

    // random traffic, checked by the per-cycle compare process
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      bin   = 1'($urandom);
      rst_n = ($urandom % 250) != 0;
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
